// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    // Stage indices into the stall control bus, shallowest stage first.
    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;

    localparam bit TRUE  = 1'b1;
    localparam bit FALSE = 1'b0;

    // One hold bit per pipeline register; bit k=1 holds stage k.
    typedef logic [STG_WB:0] stall_ctl_bus_t;

    // Multi-cycle EX sequencer states.
    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_t;

    // Hold stage k and every stage upstream of it.
    function automatic stall_ctl_bus_t hold_through(input int unsigned k);
        int unsigned mask;
        mask = (32'd1 << (k + 1)) - 32'd1;
        return mask[STG_WB:0];
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_ctrl.
// master: pipeline side (raises requests); slave: the controller.
interface pipe_ctrl_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MC_CNT_W = 6
);
    import pipe_ctrl_pkg::*;

    logic                req_if;
    logic                req_id;
    logic                req_mem;
    logic                ex_mc_start;
    logic [MC_CNT_W-1:0] ex_mc_len;
    logic                flush_req;
    logic [XLEN-1:0]     flush_tgt;

    stall_ctl_bus_t      stall;
    logic                flush;
    logic [XLEN-1:0]     flush_pc;
    logic                ex_busy;
    logic                ex_mc_done;
    logic                wdog_trip;

    modport master (
        output req_if, req_id, req_mem, ex_mc_start, ex_mc_len, flush_req, flush_tgt,
        input  stall, flush, flush_pc, ex_busy, ex_mc_done, wdog_trip
    );

    modport slave (
        input  req_if, req_id, req_mem, ex_mc_start, ex_mc_len, flush_req, flush_tgt,
        output stall, flush, flush_pc, ex_busy, ex_mc_done, wdog_trip
    );

endinterface

// File: rtl/pipe_ctrl_mc_seq.sv
// mc_seq: IDLE/BUSY/DONE sequencer for multi-cycle EX operations.
// An op of length N holds EX for N cycles, then reports done for one
// cycle (longer if MEM is holding the pipe so the result cannot move on).
module mc_seq #(
    parameter int unsigned MC_CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_mc_start,
    input  logic [MC_CNT_W-1:0] ex_mc_len,
    input  logic                mem_hold,
    output logic                ex_hold,
    output logic                ex_busy,
    output logic                ex_mc_done
);
    import pipe_ctrl_pkg::*;

    localparam logic [MC_CNT_W-1:0] CNT_ONE = MC_CNT_W'(1);

    mc_state_t           state, state_nxt;
    logic [MC_CNT_W-1:0] cnt, cnt_nxt;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MC_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: the counter covers the N-1 cycles after the start cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            MC_IDLE: begin
                if (ex_mc_start) begin
                    if (ex_mc_len <= CNT_ONE) begin
                        state_nxt = MC_DONE;
                    end else begin
                        state_nxt = MC_BUSY;
                        cnt_nxt   = ex_mc_len - CNT_ONE;
                    end
                end
            end
            MC_BUSY: begin
                if (cnt == CNT_ONE) state_nxt = MC_DONE;
                else                cnt_nxt   = cnt - CNT_ONE;
            end
            MC_DONE: begin
                if (!mem_hold) state_nxt = MC_IDLE;
            end
            default: state_nxt = MC_IDLE;
        endcase
    end

    // Outputs decoded from the registered state, all forced low in reset.
    always_comb begin
        ex_hold    = FALSE;
        ex_busy    = FALSE;
        ex_mc_done = FALSE;
        if (!rst) begin
            ex_hold    = (state == MC_IDLE && ex_mc_start) || state == MC_BUSY;
            ex_busy    = state != MC_IDLE;
            ex_mc_done = state == MC_DONE;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the 6-stage pipeline.
// Merges stage hold requests into the stall bus, sequences multi-cycle EX
// ops via mc_seq, and defers branch redirects while EX or MEM is held.
// Optional stall watchdog: define PIPE_CTRL_WDOG_EN to build it.
module pipe_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MC_CNT_W   = 6,
    parameter int unsigned WDOG_LIMIT = 1024
) (
    input logic      clk,
    input logic      rst,
    pipe_ctrl_if.slave bus
);
    import pipe_ctrl_pkg::*;

    if (WDOG_LIMIT == 0 || WDOG_LIMIT > 65535) begin : g_bad_wdog_limit
        $error("pipe_ctrl: WDOG_LIMIT must be in 1..65535");
    end

    logic            ex_hold;
    logic            ex_busy;
    logic            ex_mc_done;
    logic            hold_ex_up;
    logic            flush_c;
    logic [XLEN-1:0] flush_pc_c;
    stall_ctl_bus_t  stall_c;
    logic            wdog_trip_c;
    logic            pend;
    logic [XLEN-1:0] pend_pc;

    mc_seq #(.MC_CNT_W(MC_CNT_W)) u_mc_seq (
        .clk        (clk),
        .rst        (rst),
        .ex_mc_start(bus.ex_mc_start),
        .ex_mc_len  (bus.ex_mc_len),
        .mem_hold   (bus.req_mem),
        .ex_hold    (ex_hold),
        .ex_busy    (ex_busy),
        .ex_mc_done (ex_mc_done)
    );

    // Deepest request wins; stall[3] is derived without req_id so the flush
    // decision can mask req_id without a combinational loop.
    always_comb begin
        hold_ex_up = bus.req_mem || ex_hold;
        flush_c    = !rst && (bus.flush_req || pend) && !hold_ex_up;
        flush_pc_c = rst ? '0 : (bus.flush_req ? bus.flush_tgt : pend_pc);
        stall_c    = '0;
        if (rst)                           stall_c = '0;
        else if (bus.req_mem)              stall_c = hold_through(STG_MEM);
        else if (ex_hold)                  stall_c = hold_through(STG_EX);
        else if (bus.req_id && !flush_c)   stall_c = hold_through(STG_ID);
        else if (bus.req_if)               stall_c = hold_through(STG_IF);
    end

    // Pending redirect: captured on request, consumed when the flush fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend    <= FALSE;
            pend_pc <= '0;
        end else if (flush_c) begin
            pend    <= FALSE;
        end else if (bus.flush_req) begin
            pend    <= TRUE;
            pend_pc <= bus.flush_tgt;
        end
    end

`ifdef PIPE_CTRL_WDOG_EN
    logic [15:0] wdog_cnt;
    logic [15:0] wdog_cnt_inc;
    logic        wdog_trip_q;

    assign wdog_cnt_inc = (wdog_cnt == '1) ? wdog_cnt : wdog_cnt + 16'd1;

    // Count consecutive stalled cycles; trip sticks once the limit is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt    <= '0;
            wdog_trip_q <= FALSE;
        end else if (stall_c[STG_PC]) begin
            wdog_cnt <= wdog_cnt_inc;
            if (32'(wdog_cnt_inc) >= WDOG_LIMIT) wdog_trip_q <= TRUE;
        end else begin
            wdog_cnt <= '0;
        end
    end

    assign wdog_trip_c = !rst && wdog_trip_q;
`else
    assign wdog_trip_c = 1'b0;
`endif

    assign bus.stall      = stall_c;
    assign bus.flush      = flush_c;
    assign bus.flush_pc   = flush_pc_c;
    assign bus.ex_busy    = ex_busy;
    assign bus.ex_mc_done = ex_mc_done;
    assign bus.wdog_trip  = wdog_trip_c;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the 6-stage in-order pipeline (PC, IF, ID, EX, MEM, WB). It merges per-stage hold requests into the `StallCtlBus` vector consumed by every pipeline register, including ex_mem. It sequences multi-cycle EX operations such as divide with an internal counter FSM. It delivers branch redirects as a single-cycle flush, deferring them while EX or MEM is held.

## Interface
Parameters:
- XLEN, 32, PC/target width
- MC_CNT_W, 6, width of multi-cycle length field (max op length 2^MC_CNT_W-1)
- WDOG_LIMIT, 1024, consecutive stalled cycles before watchdog trips

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_if  in  1  fetch not ready
- req_id  in  1  load-use hazard detected in ID
- req_mem  in  1  data memory busy
- ex_mc_start  in  1  multi-cycle op present in EX this cycle (single-cycle pulse)
- ex_mc_len  in  MC_CNT_W  op length N, sampled with ex_mc_start
- flush_req  in  1  branch mispredict resolved in EX (single-cycle pulse)
- flush_tgt  in  XLEN  redirect target, sampled with flush_req
- stall  out  6  `StallCtlBus`; bit k=1 holds stage k
- flush  out  1  kill IF/ID contents, redirect PC
- flush_pc  out  XLEN  redirect target, valid with flush
- ex_busy  out  1  multi-cycle FSM not IDLE
- ex_mc_done  out  1  multi-cycle result valid this cycle
- wdog_trip  out  1  sticky watchdog error

## Operation
- Stall vector: deepest requesting stage k wins, and stall = (1<<(k+1))-1.
  - req_mem gives 6'b011111.
  - EX hold gives 6'b001111.
  - req_id gives 6'b000111.
  - req_if gives 6'b000011.
  - No request gives 6'b000000.
  - WB is never held. Stage k+1 receives a bubble whenever stall[k]=1 and stall[k+1]=0.
- EX hold = (ex_mc_start && state==IDLE) || state==BUSY.
- Multi-cycle FSM states are IDLE, BUSY, DONE.
  - IDLE + ex_mc_start: N<=1 goes to DONE. N>=2 goes to BUSY with cnt=N-1. N=0 is treated as 1.
  - BUSY: hold EX. If cnt==1, go to DONE, else decrement cnt.
  - DONE: ex_mc_done=1, no EX hold, next state IDLE.
  - ex_mc_start outside IDLE is ignored.
- Flush:
  - flush_req sets pend=1 and captures pend_pc=flush_tgt.
  - flush = (flush_req || pend) && stall[3]==0.
  - flush_pc = flush_req ? flush_tgt : pend_pc. A new flush_req overwrites pend_pc.
  - pend clears in the cycle flush asserts.
  - While flush=1, req_id is ignored (the wrong-path instruction is being killed). req_if is still honoured.
- Reset: state=IDLE, cnt=0, pend=0, pend_pc=0, wdog counter=0, wdog_trip=0.
  - While rst=1, all outputs are forced to 0, stall=6'b000000.
  - rst mid-BUSY abandons the op with no ex_mc_done.

## Timing
- stall, flush and flush_pc are combinational from current inputs and registered state, with zero-cycle response.
- ex_busy and ex_mc_done are decoded from the registered state.
- Multi-cycle op with ex_mc_start in cycle t and length N:
  - EX held cycles t..t+N-1 (N cycles).
  - ex_mc_done=1 in cycle t+N.
  - Op leaves EX at the end of t+N.
- req_mem concurrent with BUSY: stall=6'b011111, and the FSM keeps counting (functional unit runs independently).
  - If DONE coincides with req_mem, EX cannot advance.
  - In that case DONE holds until req_mem drops, and ex_mc_done stays high.
- flush_req during an EX or MEM hold: deferred, then emitted in the first cycle with stall[3]=0 as exactly one pulse.

## Configuration
- PIPE_CTRL_WDOG_EN defined:
  - A 16-bit saturating counter increments each cycle stall[0]=1 and clears when stall[0]=0.
  - When the count reaches WDOG_LIMIT, wdog_trip is set and stays high until rst.
- PIPE_CTRL_WDOG_EN undefined: no counter; wdog_trip is tied to 0.

## Structure
- Shared define.vh holds StallCtlBus, the stage index constants (STG_PC..STG_WB), the FSM state encodings, and Enabled/Disabled/True/False.
- One sub-module, `mc_seq`: the IDLE/BUSY/DONE FSM plus counter, with outputs ex_hold, ex_busy, ex_mc_done.
- Stall priority encode, flush pending logic and watchdog stay in pipe_ctrl.

## Test plan
- Single requests: req_if, req_id and req_mem each alone give stall = 000011, 000111 and 011111 respectively. req_id with req_mem together gives 011111.
- ex_mc_start, N=4 at cycle 10: stall=001111 in cycles 10-13, ex_mc_done=1 in cycle 14, back to IDLE in cycle 15. N=1: stall in cycle 10 only, done in cycle 11.
- flush_req (tgt 0x0000_0100) during BUSY, 2 cycles before end: flush=0 until EX released, then one flush pulse with flush_pc=0x100.
- flush_req with req_id in the same cycle: flush=1, stall=000000.
- rst asserted mid-BUSY: next cycle ex_busy=0, stall=0, no ex_mc_done.
- With PIPE_CTRL_WDOG_EN and WDOG_LIMIT=8, req_if held 8 cycles: wdog_trip=1 and stays high after req_if drops. Without the macro, wdog_trip stays 0.
